alu_txn_sequencer: RTL

Host-side transaction sequencer that sits directly upstream of the multi-precision byte-serial ALU and also collects its output. It accepts one complete command per handshake: precision, op and two 32-bit operands. It drives the ALU's control byte and serial operand bytes, holds the compute phase, then reads back the result bytes and flags. The assembled result is returned on a valid/ready response port.

---
 rtl/alu_pkg.sv | 65 ++++++
 rtl/alu_seq_perf.sv | 24 ++
 rtl/alu_txn_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the byte-serial ALU and its host-side transaction sequencer:
// precision and op codes, ui_in bit-field positions and the sequencer state encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    PREC_8   = 2'b00,
    PREC_16  = 2'b01,
    PREC_32  = 2'b10,
    PREC_ILL = 2'b11
  } prec_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  localparam int PREC_MSB = 7;
  localparam int OP_LSB   = 3;
  localparam int LOAD_BIT = 2;
  localparam int RSEL_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_LOAD_A  = 3'd2,
    ST_LOAD_B  = 3'd3,
    ST_COMPUTE = 3'd4,
    ST_READ    = 3'd5,
    ST_RESP    = 3'd6
  } seq_state_e;

  typedef struct packed {
    prec_e       prec;
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
  } seq_cmd_t;

  // Index of the last operand/result byte for a legal precision (N-1).
  function automatic logic [1:0] last_byte(input prec_e prec);
    case (prec)
      PREC_8:  return 2'd0;
      PREC_16: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] pack_ui(input prec_e prec, input op_e op,
                                         input logic load, input logic [1:0] rsel);
    logic [7:0] ui;
    ui                   = 8'h00;
    ui[PREC_MSB -: 2]    = prec;
    ui[OP_LSB +: 3]      = op;
    ui[LOAD_BIT]         = load;
    ui[RSEL_LSB +: 2]    = rsel;
    return ui;
  endfunction

endpackage

// File: rtl/alu_seq_perf.sv
// Saturating transaction counters for the ALU sequencer; only built when ALU_SEQ_PERF_EN is defined.
module alu_seq_perf #(
  parameter int TXN_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             txn_done,
  input  logic             err_done,
  output logic [TXN_W-1:0] perf_txn,
  output logic [ERR_W-1:0] perf_err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_txn <= '0;
      perf_err <= '0;
    end else begin
      if (txn_done && (perf_txn != '1)) perf_txn <= perf_txn + TXN_W'(1);
      if (err_done && (perf_err != '1)) perf_err <= perf_err + ERR_W'(1);
    end
  end

endmodule

// File: rtl/alu_txn_sequencer.sv
// Host-side sequencer for the byte-serial ALU: streams one command in, reads the result back.
// Define ALU_SEQ_PERF_EN to add the perf_txn / perf_err transaction counters.
module alu_txn_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned COMPUTE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_prec,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [7:0]  alu_ui,
  output logic [7:0]  alu_byte,
  input  logic [7:0]  alu_uo,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
`ifdef ALU_SEQ_PERF_EN
  output logic [15:0] perf_txn,
  output logic [7:0]  perf_err,
`endif
  output logic        rsp_err
);

  localparam logic [3:0] COMP_LAST = 4'(COMPUTE_CYCLES - 1);

  seq_state_e  state, state_nxt;
  seq_cmd_t    cmd_q;
  logic [1:0]  byte_cnt;
  logic [3:0]  comp_cnt;
  logic [1:0]  last_k;
  logic        accept;
  logic        busy;
  logic        load;
  logic [1:0]  rsel;
  logic [31:0] result_q;
  logic [3:0]  flags_q;
  logic        err_q;

  assign last_k = last_byte(cmd_q.prec);
  assign accept = cmd_valid && cmd_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (cmd_valid) state_nxt = (prec_e'(cmd_prec) == PREC_ILL) ? ST_RESP : ST_ARM;
      ST_ARM:     state_nxt = ST_LOAD_A;
      ST_LOAD_A:  if (byte_cnt == last_k) state_nxt = ST_LOAD_B;
      ST_LOAD_B:  if (byte_cnt == last_k) state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (comp_cnt == COMP_LAST) state_nxt = ST_READ;
      ST_READ:    if (byte_cnt == last_k) state_nxt = ST_RESP;
      ST_RESP:    if (rsp_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // The last COMPUTE cycle drops load so the ALU parks in idle once its final step is done.
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    busy      = 1'b0;
    load      = 1'b0;
    rsel      = 2'd0;
    alu_byte  = 8'h00;
    case (state)
      ST_ARM: begin
        busy = 1'b1;
        load = 1'b1;
      end
      ST_LOAD_A: begin
        busy     = 1'b1;
        load     = 1'b1;
        alu_byte = cmd_q.a[{byte_cnt, 3'b000} +: 8];
      end
      ST_LOAD_B: begin
        busy     = 1'b1;
        load     = 1'b1;
        alu_byte = cmd_q.b[{byte_cnt, 3'b000} +: 8];
      end
      ST_COMPUTE: begin
        busy = 1'b1;
        load = (comp_cnt != COMP_LAST);
      end
      ST_READ: begin
        busy = 1'b1;
        rsel = byte_cnt;
      end
      default: ;
    endcase
    alu_ui = busy ? pack_ui(cmd_q.prec, cmd_q.op, load, rsel) : 8'h00;
  end

  // Counters restart on every state change; result bytes above N stay at the zero loaded on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= '0;
      byte_cnt <= 2'd0;
      comp_cnt <= 4'd0;
      result_q <= 32'h0;
      flags_q  <= 4'h0;
      err_q    <= 1'b0;
    end else begin
      byte_cnt <= (state_nxt != state) ? 2'd0 : byte_cnt + 2'd1;
      comp_cnt <= (state == ST_COMPUTE && state_nxt == ST_COMPUTE) ? comp_cnt + 4'd1 : 4'd0;
      if (accept) begin
        cmd_q.prec <= prec_e'(cmd_prec);
        cmd_q.op   <= op_e'(cmd_op);
        cmd_q.a    <= cmd_a;
        cmd_q.b    <= cmd_b;
        result_q   <= 32'h0;
        flags_q    <= 4'h0;
        err_q      <= (prec_e'(cmd_prec) == PREC_ILL);
      end
      if (state == ST_READ) begin
        result_q[{byte_cnt, 3'b000} +: 8] <= alu_uo;
        if (byte_cnt == 2'd0) flags_q <= alu_flags;
      end
    end
  end

  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;

`ifdef ALU_SEQ_PERF_EN
  alu_seq_perf #(
    .TXN_W(16),
    .ERR_W(8)
  ) u_perf (
    .clk      (clk),
    .rst_n    (rst_n),
    .txn_done (rsp_valid && rsp_ready && !err_q),
    .err_done (rsp_valid && rsp_ready && err_q),
    .perf_txn (perf_txn),
    .perf_err (perf_err)
  );
`endif

endmodule
